divider_issue_ctrl: RTL and testbench
=====================================

# divider_issue_ctrl

Issue/writeback controller sitting directly upstream and downstream of the iterative divider in the complex-integer pipeline. Accepts one RISC-V DIV/DIVU/REM/REMU micro-op at a time, launches the divider, waits for completion, and returns either the quotient or the remainder with the op's tag. It keeps the last quotient/remainder pair so that a DIV/REM pair on identical operands issues only one division. It also supports pipeline flush.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- TAG_WIDTH, 6, op tag (destination/ROB id) width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  op presented
- in_ready  out  1  controller can accept op this cycle
- in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- in_src_a  in  DATA_WIDTH  dividend
- in_src_b  in  DATA_WIDTH  divisor
- in_tag  in  TAG_WIDTH  op tag
- flush  in  1  discard any op held or in flight
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  DATA_WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU)
- out_tag  out  TAG_WIDTH  tag of the returned op
- div_req  out  1  start divider (one-cycle pulse)
- div_dividend, div_divisor  out  DATA_WIDTH  divider operands
- div_is_signed  out  1  signed mode (DIV/REM)
- div_finished  in  1  divider idle/result valid
- div_quotient, div_remainder  in  DATA_WIDTH  divider results

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: in_ready = !flush.
  - Accept = in_valid & in_ready. On accept, latch op, tag, operands and signedness (signed = !in_op[0]).
  - Cache hit: cache_valid and latched operands plus signedness equal the cached ones. Go to DONE and take the result from the cache. div_req stays low.
  - Miss: drive div_req = 1 combinationally in the accept cycle, with div_dividend = in_src_a, div_divisor = in_src_b, div_is_signed = signed. Clear cache_valid. Go to WAIT.
  - Outside an accept cycle, div_* operand outputs hold the latched values.
- WAIT: in_ready = 0.
  - div_finished is ignored in the accept cycle.
  - Once in WAIT, div_finished = 1 means the result is valid. Capture div_quotient and div_remainder into the cache, store the operand key, set cache_valid, go to DONE.
- DONE: out_valid = 1.
  - out_data = in_op[1] ? cached remainder : cached quotient.
  - out_tag = latched tag.
  - On out_ready, go to IDLE. No new accept in the same cycle.
- Divider corner results (x/0 gives quotient all-ones and remainder = dividend; signed MIN/-1 gives quotient MIN and remainder 0) come from the divider. They are passed through unmodified and cached normally.
- flush has priority over all other events:
  - Next state is IDLE.
  - out_valid drops the next cycle; no accept happens in a flush cycle.
  - Flush in WAIT clears cache_valid. The divider is left running and is restarted by the next div_req, since the divider accepts a request in any phase.
  - Flush in DONE keeps the cache.
- rst: state IDLE, cache_valid 0, all latched registers 0.

## Timing
- Reset values: in_ready 0 during rst, 1 the cycle after; out_valid 0; out_data 0; out_tag 0; div_req 0; div_dividend/div_divisor 0; div_is_signed 0.
- Hit latency: accept at cycle N, out_valid at N+1.
- Miss latency: accept and div_req at N, WAIT from N+1. If div_finished is first seen high at cycle M > N, out_valid rises at M+1.
- out_valid, out_data and out_tag are stable while out_valid & !out_ready.
- div_req is asserted exactly one cycle per miss and never outside IDLE.
- Throughput: one op per (latency + 1) cycles minimum; the IDLE cycle is mandatory between ops.

## Test plan
- Miss path: DIVU 100/7, tag 3, with the real divider attached. Required: div_req pulses once, out_data = 14, out_tag = 3; out_valid rises the cycle after div_finished.
- Cache hit: REMU 100/7 immediately after the DIVU above. Required: no div_req; out_valid 1 cycle after accept; out_data = 2. Then REM 100/7 (signed): required miss, div_req asserted.
- Divide-by-zero corner: DIV 0x0000_0005/0. Required: out_data 0xFFFF_FFFF. Then REM on the same operands: required hit, out_data 5.
- Signed-overflow corner: DIV 0x8000_0000/0xFFFF_FFFF. Required: out_data 0x8000_0000. Then REM on the same operands: required out_data 0.
- Flush: flush 5 cycles into WAIT for DIV -20/3. Required: no out_valid. Then DIV -20/3 again: required miss, out_data 0xFFFF_FFFA (-6). Also flush in DONE: required out_valid low the next cycle, and a following REM -20/3 hits with out_data 0xFFFF_FFFE (-2).
- Backpressure and reset: hold out_ready low 10 cycles in DONE. Required: outputs stable and in_ready 0. Then assert rst in WAIT. Required: next cycle IDLE, out_valid 0, and the following op misses.

Source files
------------

// File: rtl/divider_issue_ctrl.sv
// Issue/writeback controller for the iterative divider. One DIV/DIVU/REM/REMU
// op at a time; a one-entry quotient/remainder cache lets a DIV/REM pair on
// identical operands share a single division.
module divider_issue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_src_a,
    input  logic [DATA_WIDTH-1:0] in_src_b,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  div_req,
    output logic [DATA_WIDTH-1:0] div_dividend,
    output logic [DATA_WIDTH-1:0] div_divisor,
    output logic                  div_is_signed,
    input  logic                  div_finished,
    input  logic [DATA_WIDTH-1:0] div_quotient,
    input  logic [DATA_WIDTH-1:0] div_remainder
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state, state_nxt;

    // Latched op
    logic [1:0]            op_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic                  sgn_q;

    // Result cache with its operand key
    logic                  cache_valid;
    logic [DATA_WIDTH-1:0] key_a, key_b;
    logic                  key_sgn;
    logic [DATA_WIDTH-1:0] quo_q, rem_q;

    logic                  in_sgn;
    logic                  accept;
    logic                  hit;
    logic                  capture;

    assign in_sgn  = ~in_op[0];
    assign in_ready = (state == IDLE) && !flush && !rst;
    assign accept  = in_valid && in_ready;
    assign hit     = cache_valid && (in_src_a == key_a) && (in_src_b == key_b)
                     && (in_sgn == key_sgn);
    // Completion only counts once we are already waiting; flush overrides it.
    assign capture = (state == WAIT) && div_finished && !flush;

    // Divider launch is combinational so the divider starts in the accept cycle.
    assign div_req       = accept && !hit;
    assign div_dividend  = div_req ? in_src_a : a_q;
    assign div_divisor   = div_req ? in_src_b : b_q;
    assign div_is_signed = div_req ? in_sgn   : sgn_q;

    assign out_valid = (state == DONE);
    assign out_data  = op_q[1] ? rem_q : quo_q;
    assign out_tag   = tag_q;

    // Next-state logic; flush forces IDLE from any state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = hit ? DONE : WAIT;
            WAIT: if (div_finished) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // State register, op latch and result cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            tag_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
            cache_valid <= 1'b0;
            key_a       <= '0;
            key_b       <= '0;
            key_sgn     <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= in_op;
                tag_q <= in_tag;
                a_q   <= in_src_a;
                b_q   <= in_src_b;
                sgn_q <= in_sgn;
            end
            if (div_req) begin
                cache_valid <= 1'b0;
            end else if (flush && state == WAIT) begin
                // The divider may finish later for an op nobody wants; drop the key.
                cache_valid <= 1'b0;
            end else if (capture) begin
                cache_valid <= 1'b1;
                key_a       <= a_q;
                key_b       <= b_q;
                key_sgn     <= sgn_q;
                quo_q       <= div_quotient;
                rem_q       <= div_remainder;
            end
        end
    end

endmodule

// File: tb/tb_divider_issue_ctrl.sv
// Scoreboard bench for divider_issue_ctrl with a behavioural divider attached.
module tb_divider_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src_a, in_src_b;
    logic [5:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_tag;
    logic        div_req;
    logic [31:0] div_dividend, div_divisor;
    logic        div_is_signed;
    logic        div_finished = 1'b1;
    logic [31:0] div_quotient = '0, div_remainder = '0;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [31:0] data; logic [5:0] tag; } exp_t;
    exp_t exp_q[$];

    // Reference-model cache state (what the controller should remember)
    bit          m_v = 0;
    logic [31:0] m_a, m_b;
    bit          m_s;
    int          exp_reqs = 0;
    int          seen_reqs = 0;
    int          div_lat = 3;
    int          cnt = 0;

    always #5 clk = ~clk;

    divider_issue_ctrl #(.DATA_WIDTH(32), .TAG_WIDTH(6)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src_a(in_src_a), .in_src_b(in_src_b), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag),
        .div_req(div_req), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_is_signed(div_is_signed), .div_finished(div_finished),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    // RISC-V M-extension division semantics: returns {quotient, remainder}.
    function automatic logic [63:0] rv_div(input logic [31:0] a, input logic [31:0] b,
                                           input bit s);
        logic [31:0] q, r;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 0;
        end else if (s) begin
            q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
        end else begin
            q = a / b; r = a % b;
        end
        return {q, r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural divider: restarts on every request, finishes after div_lat cycles.
    always @(posedge clk) begin
        if (div_req) begin
            {div_quotient, div_remainder} <= rv_div(div_dividend, div_divisor, div_is_signed);
            div_finished <= 1'b0;
            cnt <= div_lat;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) div_finished <= 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every result handshake, counts launches.
    always @(negedge clk) begin
        if (!rst && div_req) seen_reqs++;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got data 0x%0h tag %0d with empty scoreboard",
                         out_data, out_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", {32'h0, out_data}, {32'h0, e.data});
                check("out_tag", {58'h0, out_tag}, {58'h0, e.tag});
            end
        end
    end

    // One op. fmode: 0 normal, 1 flush fcyc cycles into WAIT, 2 flush in DONE,
    // 3 reset fcyc cycles into WAIT. hold = cycles out_ready stays low in DONE.
    // Entered and left at #1 after a rising edge with the DUT in IDLE.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, input int lat, input int fmode,
                         input int fcyc, input int hold);
        bit s;
        bit hit;
        int c;
        logic [63:0] qr;
        logic [31:0] exp_d, d0;
        logic [5:0]  t0;
        s = ~op[0];
        hit = m_v && a == m_a && b == m_b && s == m_s;
        qr = rv_div(a, b, s);
        exp_d = op[1] ? qr[31:0] : qr[63:32];
        div_lat = lat;
        if (!hit) exp_reqs++;
        in_valid = 1; in_op = op; in_src_a = a; in_src_b = b; in_tag = tag;
        @(negedge clk);
        check("in_ready_idle", {63'h0, in_ready}, 64'd1);
        check("div_req", {63'h0, div_req}, {63'h0, !hit});
        if (!hit) begin
            check("div_dividend", {32'h0, div_dividend}, {32'h0, a});
            check("div_divisor", {32'h0, div_divisor}, {32'h0, b});
            check("div_is_signed", {63'h0, div_is_signed}, {63'h0, s});
        end
        @(posedge clk); #1;
        in_valid = 0; in_src_a = $urandom; in_src_b = $urandom; in_tag = 6'($urandom);
        in_op = 2'($urandom);
        if (!hit) m_v = 0;
        if (fmode == 1 || fmode == 3) begin
            repeat (fcyc - 1) begin @(posedge clk); #1; end
            if (fmode == 1) flush = 1; else rst = 1;
            @(negedge clk);
            check("in_ready_wait", {63'h0, in_ready}, 64'd0);
            @(posedge clk); #1;
            flush = 0; rst = 0;
            m_v = 0;
            @(negedge clk);
            check("in_ready_after_abort", {63'h0, in_ready}, 64'd1);
            for (int i = 0; i < lat + 3; i++) begin
                check("no_out_valid_after_abort", {63'h0, out_valid}, 64'd0);
                @(negedge clk);
            end
            @(posedge clk); #1;
            return;
        end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!out_valid && c < 100);
        check("latency", c, hit ? 1 : lat + 2);
        if (!hit) begin
            m_v = 1; m_a = a; m_b = b; m_s = s;
        end
        if (fmode == 2) begin
            @(posedge clk); #1;
            flush = 1;
            @(negedge clk);
            check("in_ready_flush", {63'h0, in_ready}, 64'd0);
            @(posedge clk); #1;
            flush = 0;
            @(negedge clk);
            check("out_valid_after_flush", {63'h0, out_valid}, 64'd0);
            @(posedge clk); #1;
            return;
        end
        exp_q.push_back('{data: exp_d, tag: tag});
        d0 = out_data; t0 = out_tag;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_valid", {63'h0, out_valid}, 64'd1);
            check("hold_data", {32'h0, out_data}, {32'h0, d0});
            check("hold_tag", {58'h0, out_tag}, {58'h0, t0});
            check("hold_in_ready", {63'h0, in_ready}, 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    logic [31:0] ra, rb;
    logic [1:0]  rop;

    initial begin
        rst = 1; in_valid = 0; in_op = 0; in_src_a = 0; in_src_b = 0; in_tag = 0;
        flush = 0; out_ready = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_in_ready", {63'h0, in_ready}, 64'd0);
        check("rst_out_valid", {63'h0, out_valid}, 64'd0);
        check("rst_out_data", {32'h0, out_data}, 64'd0);
        check("rst_out_tag", {58'h0, out_tag}, 64'd0);
        check("rst_div_req", {63'h0, div_req}, 64'd0);
        check("rst_div_dividend", {32'h0, div_dividend}, 64'd0);
        check("rst_div_divisor", {32'h0, div_divisor}, 64'd0);
        check("rst_div_is_signed", {63'h0, div_is_signed}, 64'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("in_ready_after_rst", {63'h0, in_ready}, 64'd1);
        @(posedge clk); #1;

        // Directed corner sequence
        do_op(2'b01, 32'd100, 32'd7, 6'd3, 5, 0, 0, 0);            // DIVU miss -> 14
        do_op(2'b11, 32'd100, 32'd7, 6'd4, 5, 0, 0, 1);            // REMU hit  -> 2
        do_op(2'b10, 32'd100, 32'd7, 6'd5, 4, 0, 0, 0);            // REM miss
        do_op(2'b00, 32'd5, 32'd0, 6'd6, 3, 0, 0, 0);              // DIV x/0
        do_op(2'b10, 32'd5, 32'd0, 6'd7, 3, 0, 0, 0);              // REM hit -> 5
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd8, 2, 0, 0, 0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd9, 2, 0, 0, 0);
        do_op(2'b00, -32'sd20, 32'd3, 6'd10, 12, 1, 5, 0);         // flush in WAIT
        do_op(2'b00, -32'sd20, 32'd3, 6'd11, 4, 0, 0, 0);          // miss -> -6
        do_op(2'b00, -32'sd20, 32'd3, 6'd12, 4, 2, 0, 0);          // hit, flush in DONE
        do_op(2'b10, -32'sd20, 32'd3, 6'd13, 4, 0, 0, 0);          // hit -> -2
        do_op(2'b01, 32'hDEAD_BEEF, 32'd17, 6'd14, 3, 0, 0, 10);   // backpressure
        do_op(2'b00, 32'd9, 32'd2, 6'd15, 12, 3, 3, 0);            // reset in WAIT
        do_op(2'b00, 32'd9, 32'd2, 6'd16, 3, 0, 0, 0);             // misses again

        // Random ops, biased toward operand reuse and corner divisors
        ra = 32'd1; rb = 32'd1;
        for (int n = 0; n < 80; n++) begin
            rop = 2'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 4))
                    0: begin ra = $urandom; rb = 0; end
                    1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                    2: begin ra = $urandom; rb = $urandom_range(1, 20); end
                    3: begin ra = $urandom; rb = -32'($urandom_range(1, 20)); end
                    default: begin ra = $urandom; rb = $urandom; end
                endcase
            end
            do_op(rop, ra, rb, 6'($urandom), $urandom_range(1, 6),
                  ($urandom_range(0, 9) == 0) ? 2 : 0, 0, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        check("div_req_count", seen_reqs, exp_reqs);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule
